frac_clk_div: RTL and testbench
===============================

FRAC_CLK_DIV -- requirements
Module: frac_clk_div

Interface
REQ-001 Parameter channels, default 2: number of independent divider channels, 1..8.
REQ-002 Parameter acc_width, default 24: phase-accumulator width W in bits, 4..32.
REQ-003 Parameter fast_hz, default 1000000: input clock frequency.
REQ-004 Parameter slow_hz, default 38400: reset-time output rate for every channel.
REQ-005 Port clk, input, 1: the only clock; all logic updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port en, input, channels: per-channel run enable.
REQ-008 Port cfg_valid, input, 1: increment-write request.
REQ-009 Port cfg_ch, input, max(1,$clog2(channels)): target channel of the write.
REQ-010 Port cfg_inc, input, W: new phase increment for the target channel.
REQ-011 Port cfg_ready, output, 1: write accepted this cycle when high together with cfg_valid.
REQ-012 Port tick, output, channels: one-cycle pulse at each accumulator wrap.
REQ-013 Port clk_out, output, channels: divided clock, equal to the accumulator MSB, registered.

Function
REQ-014 Elaboration SHALL fail with $error if slow_hz > fast_hz, slow_hz == 0, or channels/acc_width are out of range.
REQ-015 The reset increment SHALL be inc_rst = (slow_hz * 2^W) / fast_hz, truncated, computed at elaboration in at least 64-bit arithmetic.
REQ-016 If slow_hz == fast_hz, inc_rst SHALL saturate to 2^W-1.
REQ-017 Per channel c, when en[c]=1 and no write targets c, each edge SHALL load {carry, acc[c]} <= acc[c] + inc[c], computed at W+1 bits.
REQ-018 tick[c] SHALL be registered, equal to that carry, and high for exactly the one cycle after the edge that produced the wrap.
REQ-019 clk_out[c] SHALL equal acc[c][W-1] as held after the same edge.
REQ-020 The long-run tick rate SHALL be fast_hz*inc/2^W, with no cumulative drift; individual periods SHALL be floor or ceil of 2^W/inc cycles.
REQ-021 When en[c]=0, acc[c] and clk_out[c] SHALL hold and tick[c] SHALL be 0 on the next cycle.
REQ-022 With inc[c]=0, acc[c] SHALL hold and no tick SHALL occur.
REQ-023 cfg_ready SHALL be 1 in every cycle except the cycle in which rst is high.
REQ-024 On a write (cfg_valid & cfg_ready), the next edge SHALL set inc[cfg_ch] <= cfg_inc and acc[cfg_ch] <= 0, and tick[cfg_ch] SHALL be 0 on the next cycle.
REQ-025 The write SHALL take priority over en for the same channel in the same cycle; other channels SHALL be unaffected.
REQ-026 A write with cfg_ch >= channels SHALL be accepted and ignored.
REQ-027 Channels SHALL be fully independent; simultaneous wraps on several channels SHALL each produce their own tick.

Reset
REQ-028 While rst is high at an edge, that edge SHALL set every acc to 0, every inc to inc_rst, and tick and clk_out to 0.
REQ-029 A write presented in the same cycle as rst SHALL be discarded.
REQ-030 Reset asserted mid-period SHALL abandon the period; counting SHALL restart from 0 on the first edge with rst low.

Structure
REQ-031 Package clk_div_pkg SHALL hold the range-check constants and function calc_inc(fast_hz, slow_hz, width), which returns the 64-bit increment.
REQ-032 One sub-module, frac_div_ch, SHALL implement a single channel (acc, inc, tick, clk_out); the top SHALL generate channels instances of it and decode cfg_ch.

Verification
REQ-033 W=8, inc=64, en=1 after reset -> tick every 4th cycle; clk_out is 2 cycles high and 2 cycles low.
REQ-034 W=8, inc=96 -> exactly 3 ticks per 8 cycles, with spacing 3,3,2 repeating; 300 ticks in 800 cycles.
REQ-035 fast_hz=1000000, slow_hz=38400, W=24 -> inc_rst=644245; tick count over 10^6 cycles is 38400 +/- 1.
REQ-036 Channel 0 running, write cfg_ch=0, cfg_inc=128 in the same cycle as en[0]=1 -> acc0=0 next cycle; tick0 first at cycle +2 and then every 2 cycles; channel 1 phase unchanged.
REQ-037 en[1] dropped for 5 cycles mid-period -> tick1 and clk_out1 hold (tick1=0), and the period stretches by exactly 5 cycles.
REQ-038 rst pulsed for 1 cycle mid-period with a pending write -> all outputs 0, inc restored to inc_rst, write discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and elaboration-time helpers for the fractional clock divider.
//   CH_MIN/CH_MAX : legal range of the channel count
//   W_MIN/W_MAX   : legal range of the phase-accumulator width
//   calc_inc()    : reset-time phase increment, 64-bit, saturated to 2^W-1
//   ch_w()        : width of the channel-select field
package clk_div_pkg;

  localparam int CH_MIN = 1;
  localparam int CH_MAX = 8;
  localparam int W_MIN  = 4;
  localparam int W_MAX  = 32;

  // (slow * 2^width) / fast, truncated. slow == fast would give exactly 2^width,
  // which does not fit the accumulator, so the result saturates to 2^width-1.
  function automatic logic [63:0] calc_inc(input logic [63:0] fast_hz,
                                           input logic [63:0] slow_hz,
                                           input int          width);
    logic [63:0] full;
    logic [63:0] q;
    full = 64'd1 << width;
    if (fast_hz == 64'd0) begin
      q = full - 64'd1;
    end else begin
      q = (slow_hz << width) / fast_hz;
    end
    if (q >= full) begin
      q = full - 64'd1;
    end
    return q;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frac_div_ch.sv
// One fractional divider channel: phase accumulator plus its increment.
//   clk, rst     : clock and synchronous active-high reset
//   en           : run enable
//   wr, wr_inc   : load a new increment and restart the phase from 0
//   tick         : one-cycle pulse on accumulator wrap (registered carry)
//   clk_out      : accumulator MSB
module frac_div_ch
  import clk_div_pkg::*;
#(
  parameter int                    acc_width = 24,
  parameter logic [acc_width-1:0]  inc_rst   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wr,
  input  logic [acc_width-1:0] wr_inc,
  output logic                 tick,
  output logic                 clk_out
);

  logic [acc_width-1:0] acc_p1;
  logic [acc_width-1:0] inc_p1;
  logic                 tick_p1;
  logic [acc_width:0]   sum_p0;

  // Stage 0: next phase with carry, one bit wider than the accumulator
  always_comb begin
    sum_p0 = {1'b0, acc_p1} + {1'b0, inc_p1};
  end

  // Stage 1: accumulator, increment and wrap pulse; a write outranks en
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p1  <= '0;
      inc_p1  <= inc_rst;
      tick_p1 <= 1'b0;
    end else if (wr) begin
      acc_p1  <= '0;
      inc_p1  <= wr_inc;
      tick_p1 <= 1'b0;
    end else if (en) begin
      acc_p1  <= sum_p0[acc_width-1:0];
      tick_p1 <= sum_p0[acc_width];
    end else begin
      tick_p1 <= 1'b0;
    end
  end

  assign tick    = tick_p1;
  assign clk_out = acc_p1[acc_width-1];

endmodule

// File: rtl/frac_clk_div.sv
// Multi-channel fractional clock divider.
//   clk, rst             : clock and synchronous active-high reset
//   en[channels]         : per-channel run enable
//   cfg_valid/cfg_ready  : increment-write handshake (ready low only during reset)
//   cfg_ch, cfg_inc      : target channel and new increment; unknown channels ignored
//   tick[channels]       : wrap pulses
//   clk_out[channels]    : divided clocks (accumulator MSBs)
module frac_clk_div
  import clk_div_pkg::*;
#(
  parameter int          channels  = 2,
  parameter int          acc_width = 24,
  parameter int unsigned fast_hz   = 1000000,
  parameter int unsigned slow_hz   = 38400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [channels-1:0]        en,
  input  logic                       cfg_valid,
  input  logic [ch_w(channels)-1:0]  cfg_ch,
  input  logic [acc_width-1:0]       cfg_inc,
  output logic                       cfg_ready,
  output logic [channels-1:0]        tick,
  output logic [channels-1:0]        clk_out
);

  localparam int          CH_W      = ch_w(channels);
  localparam logic [63:0] INC_RST64 = calc_inc(64'(fast_hz), 64'(slow_hz), acc_width);
  localparam logic [acc_width-1:0] INC_RST = INC_RST64[acc_width-1:0];

  if (channels < CH_MIN || channels > CH_MAX || acc_width < W_MIN || acc_width > W_MAX ||
      slow_hz == 0 || slow_hz > fast_hz) begin : g_bad_params
    $error("frac_clk_div: illegal parameters channels=%0d acc_width=%0d fast_hz=%0d slow_hz=%0d",
           channels, acc_width, fast_hz, slow_hz);
  end

  // A write in the reset cycle is not accepted, so it is simply dropped.
  assign cfg_ready = ~rst;

  for (genvar c = 0; c < channels; c++) begin : g_ch
    logic wr;
    // cfg_ch values at or beyond channels match no instance and are ignored.
    assign wr = cfg_valid & cfg_ready & (cfg_ch == CH_W'(c));

    frac_div_ch #(
      .acc_width (acc_width),
      .inc_rst   (INC_RST)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[c]),
      .wr      (wr),
      .wr_inc  (cfg_inc),
      .tick    (tick[c]),
      .clk_out (clk_out[c])
    );
  end

endmodule

// File: tb/tb_frac_clk_div.sv
module tb_frac_clk_div;
  import clk_div_pkg::*;

  localparam int NCH = 3;
  localparam int W   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_inc;
  logic           cfg_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;

  int total = 0;
  int bad   = 0;

  // fast=1000, slow=250, W=8 -> reset increment 64 (tick every 4 cycles)
  frac_clk_div #(
    .channels  (NCH),
    .acc_width (W),
    .fast_hz   (1000),
    .slow_hz   (250)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    step;
    rst = 1'b0;
  endtask

  task automatic test_calc_inc;
    logic [63:0] v;
    v = calc_inc(64'd1000000, 64'd38400, 24);
    total++;
    if (v !== 64'd644245) begin bad++; $display("FAIL calc_inc_24: got %0d want 644245", v); end
    v = calc_inc(64'd100, 64'd100, 8);
    total++;
    if (v !== 64'd255) begin bad++; $display("FAIL calc_inc_sat: got %0d want 255", v); end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = '1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    step; step;
    total++;
    if (tick !== 3'b000) begin bad++; $display("FAIL reset_tick: got %b want 000", tick); end
    total++;
    if (clk_out !== 3'b000) begin bad++; $display("FAIL reset_clk_out: got %b want 000", clk_out); end
    total++;
    if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
    rst = 1'b0; en = '0;
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", cfg_ready); end
  endtask

  task automatic test_div4;
    logic [NCH-1:0] et, ec;
    do_reset;
    en = '1;
    for (int e = 1; e <= 8; e++) begin
      step;
      et = (e % 4 == 0) ? 3'b111 : 3'b000;
      ec = (e % 4 == 2 || e % 4 == 3) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et) begin bad++; $display("FAIL div4_tick e=%0d: got %b want %b", e, tick, et); end
      total++;
      if (clk_out !== ec) begin bad++; $display("FAIL div4_clk e=%0d: got %b want %b", e, clk_out, ec); end
    end
  endtask

  task automatic test_frac;
    int cnt0, cnt1;
    logic et;
    do_reset;
    en = '1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd96;
    step;
    cfg_valid = 1'b0;
    total++;
    if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      bad++; $display("FAIL frac_write: got tick=%b clk=%b want 0 0", tick[0], clk_out[0]);
    end
    cnt0 = 0; cnt1 = 0;
    for (int k = 1; k <= 800; k++) begin
      step;
      cnt0 += int'(tick[0]);
      cnt1 += int'(tick[1]);
      if (k <= 8) begin
        et = (k == 3 || k == 6 || k == 8);
        total++;
        if (tick[0] !== et) begin bad++; $display("FAIL frac_spacing k=%0d: got %b want %b", k, tick[0], et); end
      end
    end
    total++;
    if (cnt0 != 300) begin bad++; $display("FAIL frac_count: got %0d want 300", cnt0); end
    total++;
    if (cnt1 != 200) begin bad++; $display("FAIL frac_ch1_count: got %0d want 200", cnt1); end
  endtask

  task automatic test_write_priority;
    logic et0, ec0, et1, ec1;
    do_reset;
    en = '1;
    step;                                    // edge 1: all acc = 64
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;
    step;                                    // edge 2: acc0 = 0, acc1 = 128
    cfg_valid = 1'b0;
    total++;
    if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      bad++; $display("FAIL prio_write: got tick0=%b clk0=%b want 0 0", tick[0], clk_out[0]);
    end
    total++;
    if (clk_out[1] !== 1'b1) begin bad++; $display("FAIL prio_ch1_phase: got %b want 1", clk_out[1]); end
    for (int e = 3; e <= 10; e++) begin
      step;
      et0 = (e % 2 == 0); ec0 = (e % 2 == 1);
      et1 = (e % 4 == 0); ec1 = (e % 4 == 2 || e % 4 == 3);
      total++;
      if (tick[0] !== et0 || clk_out[0] !== ec0) begin
        bad++; $display("FAIL prio_ch0 e=%0d: got %b%b want %b%b", e, tick[0], clk_out[0], et0, ec0);
      end
      total++;
      if (tick[1] !== et1 || clk_out[1] !== ec1) begin
        bad++; $display("FAIL prio_ch1 e=%0d: got %b%b want %b%b", e, tick[1], clk_out[1], et1, ec1);
      end
    end
  endtask

  task automatic test_en_hold;
    do_reset;
    en = '1;
    step; step;                              // acc1 = 128, clk_out1 = 1
    en = 3'b101;
    for (int k = 1; k <= 5; k++) begin
      step;
      total++;
      if (tick[1] !== 1'b0 || clk_out[1] !== 1'b1) begin
        bad++; $display("FAIL hold k=%0d: got tick1=%b clk1=%b want 0 1", k, tick[1], clk_out[1]);
      end
    end
    en = '1;
    step;                                    // acc1 = 192
    total++;
    if (tick[1] !== 1'b0 || clk_out[1] !== 1'b1) begin
      bad++; $display("FAIL hold_resume1: got tick1=%b clk1=%b want 0 1", tick[1], clk_out[1]);
    end
    step;                                    // wrap, stretched by 5 cycles
    total++;
    if (tick[1] !== 1'b1 || clk_out[1] !== 1'b0) begin
      bad++; $display("FAIL hold_resume2: got tick1=%b clk1=%b want 1 0", tick[1], clk_out[1]);
    end
    en = 3'b101;
    step;
    total++;
    if (tick[1] !== 1'b0) begin bad++; $display("FAIL hold_tick_clear: got %b want 0", tick[1]); end
  endtask

  task automatic test_zero_inc;
    int cnt0;
    logic seen2;
    do_reset;
    en = '1; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd0;
    step;
    cfg_valid = 1'b0;
    cnt0 = 0; seen2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step;
      cnt0 += int'(tick[0]);
      seen2 |= tick[2] | clk_out[2];
    end
    total++;
    if (seen2 !== 1'b0) begin bad++; $display("FAIL zero_inc_ch2: got activity=%b want 0", seen2); end
    total++;
    if (cnt0 != 5) begin bad++; $display("FAIL zero_inc_ch0: got %0d want 5", cnt0); end
  endtask

  task automatic test_out_of_range;
    logic [NCH-1:0] et, ec;
    do_reset;
    en = '1; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd200;
    for (int e = 1; e <= 8; e++) begin
      step;
      cfg_valid = 1'b0;
      et = (e % 4 == 0) ? 3'b111 : 3'b000;
      ec = (e % 4 == 2 || e % 4 == 3) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et || clk_out !== ec) begin
        bad++; $display("FAIL oor e=%0d: got tick=%b clk=%b want %b %b", e, tick, clk_out, et, ec);
      end
    end
  endtask

  task automatic test_reset_write;
    logic [NCH-1:0] et, ec;
    do_reset;
    en = '1;
    step; step;                              // mid-period, clk_out = 111
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd32;
    step;
    total++;
    if (tick !== 3'b000 || clk_out !== 3'b000 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL rstw_outputs: got tick=%b clk=%b rdy=%b want 000 000 0", tick, clk_out, cfg_ready);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step;
      et = (e % 4 == 0) ? 3'b111 : 3'b000;
      ec = (e % 4 == 2 || e % 4 == 3) ? 3'b111 : 3'b000;
      total++;
      if (tick !== et || clk_out !== ec) begin
        bad++; $display("FAIL rstw e=%0d: got tick=%b clk=%b want %b %b", e, tick, clk_out, et, ec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
    test_calc_inc;
    test_reset;
    test_div4;
    test_frac;
    test_write_priority;
    test_en_hold;
    test_zero_inc;
    test_out_of_range;
    test_reset_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
